// File: rtl/dfu_pkg.sv
// Shared constants and read-FSM state type for the DFU output buffer.
package dfu_pkg;

  localparam int DFU_NUM_BANKS       = 8;
  localparam int DFU_BANK_W          = 48;
  localparam int DFU_DEPTH           = 16;
  localparam int DFU_ADDR_W          = 4;
  localparam int DFU_AXI_RDATA_WIDTH = 64;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_e;

endpackage

// File: rtl/dfu_bank_ram.sv
// One output-buffer bank: 1 write port, 1 synchronous read-before-write read port.
// With DFU_OUT_BUF_PARITY_EN defined each word carries an even-parity bit.
module dfu_bank_ram #(
  parameter int BANK_W = 48,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [BANK_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [BANK_W-1:0] rdata_o,
  output logic              par_err_o
);

`ifdef DFU_OUT_BUF_PARITY_EN
  localparam int STORE_W = BANK_W + 1;
`else
  localparam int STORE_W = BANK_W;
`endif

  logic [STORE_W-1:0] mem_q [DEPTH];
  logic [STORE_W-1:0] rd_q;
  logic [STORE_W-1:0] wword;

`ifdef DFU_OUT_BUF_PARITY_EN
  assign wword     = {^wdata_i, wdata_i};
  assign par_err_o = ^rd_q;
`else
  assign wword     = wdata_i;
  assign par_err_o = 1'b0;
`endif

  assign rdata_o = rd_q[BANK_W-1:0];

  // Storage is deliberately not reset; the read register samples old contents
  // when the same row is written on the same edge.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wword;
    if (re_i) rd_q <= mem_q[raddr_i];
  end

endmodule

// File: rtl/dfu_out_buf.sv
// DFU output buffer: row writes into NUM_BANKS banks, AXI-style burst readback
// of one row (one beat per bank). Optional parity via DFU_OUT_BUF_PARITY_EN.
module dfu_out_buf
  import dfu_pkg::*;
#(
  parameter int NUM_BANKS       = DFU_NUM_BANKS,
  parameter int BANK_W          = DFU_BANK_W,
  parameter int DEPTH           = DFU_DEPTH,
  parameter int ADDR_W          = DFU_ADDR_W,
  parameter int AXI_RDATA_WIDTH = DFU_AXI_RDATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BANK_W-1:0]          sys2dfu_data_out_c [NUM_BANKS],
  input  logic                       sys2dfu_data_out_c_vld,
  input  logic                       idu2dfu_tile_clr,
  output logic                       dfu2idu_compute_done,
  input  logic [ADDR_W-1:0]          ar2dfu_axi_addr,
  input  logic                       ar2dfu_axi_addr_vld,
  output logic                       dfu2ar_axi_addr_rdy,
  output logic [AXI_RDATA_WIDTH-1:0] dfu2ar_axi_data_out,
  output logic                       dfu2ar_axi_data_out_vld,
  input  logic                       ar2dfu_axi_data_rdy,
  output logic                       dfu2ar_axi_rd_last,
  output logic                       dfu2ar_axi_rd_err,
  output logic                       ack_sram_c_rd,
  output logic                       dfu2idu_par_err
);

  localparam int BEAT_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [ADDR_W-1:0] LAST_ROW    = ADDR_W'(DEPTH - 1);
  localparam logic [BEAT_W-1:0] PENULT_BEAT = BEAT_W'(NUM_BANKS - 2);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both 1; valid never drops and data never changes until that edge.

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              done_q, done_d;
  logic              wr_en;

  assign wr_en = sys2dfu_data_out_c_vld && !idu2dfu_tile_clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    done_d   = 1'b0;
    if (idu2dfu_tile_clr) begin
      wr_ptr_d = '0;
    end else if (sys2dfu_data_out_c_vld) begin
      wr_ptr_d = (wr_ptr_q == LAST_ROW) ? '0 : wr_ptr_q + 1'b1;
      done_d   = (wr_ptr_q == LAST_ROW);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      done_q   <= done_d;
    end
  end

  assign dfu2idu_compute_done = done_q;

  rd_state_e         state_q;
  logic              addr_rdy_q, vld_q, last_q, err_q, ack_q, oob_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BANK_W-1:0] snap_q    [NUM_BANKS];
  logic [BANK_W-1:0] ram_rdata [NUM_BANKS];
  logic [NUM_BANKS-1:0] ram_par_err;
  logic              addr_hs, addr_oob, rd_en;

  assign addr_hs  = ar2dfu_axi_addr_vld && addr_rdy_q;
  assign addr_oob = (32'(ar2dfu_axi_addr) >= DEPTH);
  // The RAM read register acts as the address latch: banks are read on the
  // handshake edge and the data is ready during FETCH.
  assign rd_en    = addr_hs && !addr_oob;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    dfu_bank_ram #(
      .BANK_W (BANK_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk       (clk),
      .we_i      (wr_en),
      .waddr_i   (wr_ptr_q),
      .wdata_i   (sys2dfu_data_out_c[b]),
      .re_i      (rd_en),
      .raddr_i   (ar2dfu_axi_addr),
      .rdata_o   (ram_rdata[b]),
      .par_err_o (ram_par_err[b])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RD_IDLE;
      addr_rdy_q <= 1'b0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      oob_q      <= 1'b0;
      beat_q     <= '0;
      for (int b = 0; b < NUM_BANKS; b++) snap_q[b] <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        RD_IDLE: begin
          addr_rdy_q <= 1'b1;
          if (addr_hs) begin
            addr_rdy_q <= 1'b0;
            oob_q      <= addr_oob;
            state_q    <= RD_FETCH;
          end
        end
        RD_FETCH: begin
          for (int b = 0; b < NUM_BANKS; b++) snap_q[b] <= oob_q ? '0 : ram_rdata[b];
          beat_q  <= '0;
          vld_q   <= 1'b1;
          last_q  <= (NUM_BANKS == 1);
          err_q   <= oob_q;
          state_q <= RD_STREAM;
        end
        RD_STREAM: begin
          if (vld_q && ar2dfu_axi_data_rdy) begin
            if (last_q) begin
              vld_q      <= 1'b0;
              last_q     <= 1'b0;
              err_q      <= 1'b0;
              ack_q      <= 1'b1;
              addr_rdy_q <= 1'b1;
              state_q    <= RD_IDLE;
            end else begin
              beat_q <= beat_q + 1'b1;
              last_q <= (beat_q == PENULT_BEAT);
            end
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  assign dfu2ar_axi_addr_rdy     = addr_rdy_q;
  assign dfu2ar_axi_data_out     = AXI_RDATA_WIDTH'(snap_q[beat_q]);
  assign dfu2ar_axi_data_out_vld = vld_q;
  assign dfu2ar_axi_rd_last      = last_q;
  assign dfu2ar_axi_rd_err       = err_q;
  assign ack_sram_c_rd           = ack_q;

`ifdef DFU_OUT_BUF_PARITY_EN
  logic par_err_q;

  // Sticky: only an in-range FETCH consults the parity; tile clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err_q <= 1'b0;
    end else if (idu2dfu_tile_clr) begin
      par_err_q <= 1'b0;
    end else if (state_q == RD_FETCH && !oob_q && |ram_par_err) begin
      par_err_q <= 1'b1;
    end
  end

  assign dfu2idu_par_err = par_err_q;
`else
  logic unused_ram_par;
  assign unused_ram_par  = ^ram_par_err;
  assign dfu2idu_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_dfu_out_buf.sv
// Directed self-checking bench for dfu_out_buf (DEPTH=16 instance plus a
// DEPTH=12 instance sharing the same inputs for the out-of-range read).
module tb_dfu_out_buf;
  import dfu_pkg::*;

  localparam int NB = 8;
  localparam int BW = 48;
  localparam int DW = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [BW-1:0] wdata [NB];
  logic          wvld, clr, arvld, drdy, sel12;
  logic [3:0]    araddr;

  logic          d16_done, d16_ardy, d16_vld, d16_last, d16_err, d16_ack, d16_par;
  logic          d12_done, d12_ardy, d12_vld, d12_last, d12_err, d12_ack, d12_par;
  logic [DW-1:0] d16_data, d12_data;

  dfu_out_buf dut16 (
    .clk(clk), .rst(rst),
    .sys2dfu_data_out_c(wdata), .sys2dfu_data_out_c_vld(wvld),
    .idu2dfu_tile_clr(clr), .dfu2idu_compute_done(d16_done),
    .ar2dfu_axi_addr(araddr), .ar2dfu_axi_addr_vld(arvld), .dfu2ar_axi_addr_rdy(d16_ardy),
    .dfu2ar_axi_data_out(d16_data), .dfu2ar_axi_data_out_vld(d16_vld),
    .ar2dfu_axi_data_rdy(drdy), .dfu2ar_axi_rd_last(d16_last), .dfu2ar_axi_rd_err(d16_err),
    .ack_sram_c_rd(d16_ack), .dfu2idu_par_err(d16_par)
  );

  dfu_out_buf #(.DEPTH(12), .ADDR_W(4)) dut12 (
    .clk(clk), .rst(rst),
    .sys2dfu_data_out_c(wdata), .sys2dfu_data_out_c_vld(wvld),
    .idu2dfu_tile_clr(clr), .dfu2idu_compute_done(d12_done),
    .ar2dfu_axi_addr(araddr), .ar2dfu_axi_addr_vld(arvld), .dfu2ar_axi_addr_rdy(d12_ardy),
    .dfu2ar_axi_data_out(d12_data), .dfu2ar_axi_data_out_vld(d12_vld),
    .ar2dfu_axi_data_rdy(drdy), .dfu2ar_axi_rd_last(d12_last), .dfu2ar_axi_rd_err(d12_err),
    .ack_sram_c_rd(d12_ack), .dfu2idu_par_err(d12_par)
  );

  logic          o_done, o_ardy, o_vld, o_last, o_err, o_ack, o_par;
  logic [DW-1:0] o_data;
  assign o_done = sel12 ? d12_done : d16_done;
  assign o_ardy = sel12 ? d12_ardy : d16_ardy;
  assign o_vld  = sel12 ? d12_vld  : d16_vld;
  assign o_last = sel12 ? d12_last : d16_last;
  assign o_err  = sel12 ? d12_err  : d16_err;
  assign o_ack  = sel12 ? d12_ack  : d16_ack;
  assign o_par  = sel12 ? d12_par  : d16_par;
  assign o_data = sel12 ? d12_data : d16_data;

  // scoreboard
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [BW-1:0] model16 [16][NB];
  int            exp_ptr = 0;
  logic          done_exp = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] word(input int gen, input int r, input int b);
    return {8'(gen), 8'(r), 8'(b), 24'h5A3C96};
  endfunction

  // driver tasks
  task automatic strobe(input int gen, input bit c);
    @(posedge clk); #1;
    for (int b = 0; b < NB; b++) wdata[b] = word(gen, exp_ptr, b);
    wvld = 1'b1;
    clr  = c;
    @(negedge clk);
    check("done", o_done, done_exp);
    if (c) begin
      done_exp = 1'b0;
      exp_ptr  = 0;
    end else begin
      done_exp = (exp_ptr == 15);
      for (int b = 0; b < NB; b++) model16[exp_ptr][b] = wdata[b];
      exp_ptr = (exp_ptr + 1) % 16;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    wvld = 1'b0;
    clr  = 1'b0;
    @(negedge clk);
    check("done", o_done, done_exp);
    done_exp = 1'b0;
  endtask

  // wgen >= 0 also presents a write strobe in the address-handshake cycle
  task automatic read(input logic [3:0] addr, input bit toggle, input bit exp_err, input int wgen);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int beats = 0;
    int cyc   = 0;
    int first = -1;
    exp_q.delete();
    for (int b = 0; b < NB; b++) exp_q.push_back(exp_err ? '0 : 64'(model16[addr][b]));
    @(posedge clk); #1;
    araddr = addr;
    arvld  = 1'b1;
    drdy   = 1'b1;
    if (wgen >= 0) begin
      for (int b = 0; b < NB; b++) wdata[b] = word(wgen, exp_ptr, b);
      wvld = 1'b1;
    end
    @(negedge clk);
    check("addr_rdy_idle", o_ardy, 1'b1);
    @(posedge clk); #1;
    arvld = 1'b0;
    if (wgen >= 0) begin
      wvld = 1'b0;
      for (int b = 0; b < NB; b++) model16[exp_ptr][b] = wdata[b];
      exp_ptr = (exp_ptr + 1) % 16;
    end
    while (beats < NB && cyc < 60) begin
      cyc++;
      drdy = toggle ? pat[cyc % 4] : 1'b1;
      @(negedge clk);
      if (o_vld) begin
        if (first < 0) first = cyc;
        check("addr_rdy_busy", o_ardy, 1'b0);
        check("beat_data", o_data, exp_q[0]);
        check("beat_err", o_err, exp_err);
        check("beat_last", o_last, (beats == NB - 1));
        if (drdy) begin
          void'(exp_q.pop_front());
          beats++;
        end
      end else begin
        check("ack_early", o_ack, 1'b0);
      end
      @(posedge clk); #1;
    end
    drdy = 1'b0;
    check("first_beat_latency", 64'(first), 64'd2);
    check("handshakes", 64'(beats), 64'(NB));
    @(negedge clk);
    check("ack_pulse", o_ack, 1'b1);
    check("vld_after_last", o_vld, 1'b0);
    check("addr_rdy_after", o_ardy, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("ack_single", o_ack, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wvld = 1'b0; clr = 1'b0; arvld = 1'b0; drdy = 1'b0; araddr = '0; sel12 = 1'b0;
    for (int b = 0; b < NB; b++) wdata[b] = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_addr_rdy", o_ardy, 1'b0);
    check("rst_vld", o_vld, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_ack", o_ack, 1'b0);
    check("rst_data", o_data, '0);
    check("rst_last", o_last, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_par", o_par, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("addr_rdy_rise", o_ardy, 1'b1);

    // fill all 16 rows; done after strobe 16 only
    for (int r = 0; r < 16; r++) strobe(0, 1'b0);
    idle();
    idle();
    check("wr_ptr_wrap", 64'(dut16.wr_ptr_q), 64'd0);

    read(4'd5, 1'b0, 1'b0, -1);
    read(4'd3, 1'b1, 1'b0, -1);

    // read-before-write on row 2, then the new data
    strobe(1, 1'b0);
    strobe(1, 1'b0);
    idle();
    begin
      logic [BW-1:0] old_b0;
      old_b0 = model16[2][0];
      read(4'd2, 1'b0, 1'b0, 1);
      check("row2_updated", 64'(model16[2][0] != old_b0), 64'd1);
    end
    read(4'd2, 1'b0, 1'b0, -1);

    // tile clear on the 16th strobe
    strobe(9, 1'b1);
    for (int r = 0; r < 15; r++) strobe(2, 1'b0);
    strobe(2, 1'b1);
    idle();
    idle();
    check("wr_ptr_clr", 64'(dut16.wr_ptr_q), 64'd0);
    read(4'd15, 1'b0, 1'b0, -1);
    read(4'd14, 1'b1, 1'b0, -1);

    // out-of-range read on the DEPTH=12 instance
    sel12 = 1'b1;
    read(4'd13, 1'b0, 1'b1, -1);
    sel12 = 1'b0;

    // reset in the middle of a burst
    @(posedge clk); #1;
    araddr = 4'd5; arvld = 1'b1; drdy = 1'b1;
    @(posedge clk); #1 arvld = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_vld", o_vld, 1'b0);
      check("midrst_ack", o_ack, 1'b0);
      check("midrst_addr_rdy", o_ardy, 1'b0);
    end
    @(posedge clk); #1 rst = 1'b1; drdy = 1'b0;
    exp_ptr  = 0;
    done_exp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ack_after", o_ack, 1'b0);
    check("midrst_addr_rdy_rise", o_ardy, 1'b1);

`ifdef DFU_OUT_BUF_PARITY_EN
    dut16.g_bank[4].u_ram.mem_q[1][0] = ~dut16.g_bank[4].u_ram.mem_q[1][0];
    model16[1][4][0] = ~model16[1][4][0];
    read(4'd1, 1'b0, 1'b0, -1);
    check("par_err_set", o_par, 1'b1);
    idle();
    check("par_err_held", o_par, 1'b1);
    strobe(0, 1'b1);
    idle();
    check("par_err_cleared", o_par, 1'b0);
`else
    read(4'd1, 1'b0, 1'b0, -1);
    check("par_err_tied", o_par, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
